// File: rtl/mem_arbiter_pkg.sv
// Shared FSM encodings, burst constants and counter width for mem_arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RADDR = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WADDR = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_WRESP = 3'd5;

  localparam int BEAT_W = 4;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  function automatic logic [7:0] burst_len(input int beats);
    return 8'(beats - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_reg.sv
// Enable-loaded register with asynchronous active-low clear.
// Holds the granted request's payload for the whole transaction.
module mem_arbiter_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter onto a single-outstanding AXI4 subset master.
// Define MEM_ARB_RR_EN for round-robin; otherwise dcache has priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_BEATS = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic [63:0]       ic_rdata,
  output logic              ic_rlast,
  input  logic              ic_kill,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [63:0]       dc_wdata,
  input  logic [7:0]        dc_wstrb,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic [63:0]       dc_rdata,
  output logic              dc_rlast,
  output logic              dc_bdone,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic              rlast,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready
);

  localparam int LAT_W = 1 + ADDR_W + 64 + 8;

  logic [2:0]        state_q, state_d;
  logic              kill_q, kill_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              idle, fav_dc, win_dc, win_ic;
  logic              rd_beat;
  logic [LAT_W-1:0]  lat_d, lat_q;
  logic              own_dc;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0]       lat_wdata;
  logic [7:0]        lat_wstrb;

`ifdef MEM_ARB_RR_EN
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (win_dc)      rr_d = 1'b0;
    else if (win_ic) rr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= 1'b1;
    else      rr_q <= rr_d;
  end

  assign fav_dc = rr_q;
`else
  assign fav_dc = 1'b1;
`endif

  // Grants are gated by reset so nothing leaks out while held.
  assign idle   = (state_q == S_IDLE);
  assign win_dc = rst && idle && dc_req && (fav_dc || !ic_req);
  assign win_ic = rst && idle && ic_req && !win_dc;

  always_comb begin
    lat_d = {1'b0, ic_addr, 64'd0, 8'd0};
    if (win_dc) lat_d = {1'b1, dc_addr, dc_wdata, dc_wstrb};
  end

  mem_arbiter_reg #(.W(LAT_W)) u_lat (
    .clk (clk),
    .rst (rst),
    .en  (win_dc | win_ic),
    .d   (lat_d),
    .q   (lat_q)
  );

  assign {own_dc, lat_addr, lat_wdata, lat_wstrb} = lat_q;

  assign rd_beat = (state_q == S_RDATA) && rvalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_dc)      state_d = dc_we ? S_WADDR : S_RADDR;
        else if (win_ic) state_d = S_RADDR;
      end
      S_RADDR: if (arready)          state_d = S_RDATA;
      S_RDATA: if (rvalid && rlast)  state_d = S_IDLE;
      S_WADDR: if (awready)          state_d = S_WDATA;
      S_WDATA: if (wready)           state_d = S_WRESP;
      S_WRESP: if (bvalid)           state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    kill_d = kill_q;
    if (idle) kill_d = 1'b0;
    else if (ic_kill && !own_dc &&
             (state_q == S_RADDR || state_q == S_RDATA))
      kill_d = 1'b1;
  end

  always_comb begin
    beat_d = beat_q;
    if (idle)         beat_d = '0;
    else if (rd_beat) beat_d = beat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      beat_q  <= beat_d;
    end
  end

  assign ic_gnt = win_ic;
  assign dc_gnt = win_dc;

  assign arvalid = (state_q == S_RADDR);
  assign araddr  = lat_addr;
  assign arlen   = own_dc ? AXI_LEN_SINGLE : burst_len(LINE_BEATS);
  assign rready  = (state_q == S_RDATA);

  // A kill in the same cycle as a beat already hides that beat.
  assign ic_rvalid = rd_beat && !own_dc && !kill_q && !ic_kill;
  assign ic_rdata  = rdata;
  assign ic_rlast  = ic_rvalid && rlast;
  assign dc_rvalid = rd_beat && own_dc;
  assign dc_rdata  = rdata;
  assign dc_rlast  = dc_rvalid && rlast;

  assign awvalid  = (state_q == S_WADDR);
  assign awaddr   = lat_addr;
  assign wvalid   = (state_q == S_WDATA);
  assign wdata    = lat_wdata;
  assign wstrb    = lat_wstrb;
  assign wlast    = wvalid;
  assign bready   = (state_q == S_WRESP);
  assign dc_bdone = bready && bvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Build with MEM_ARB_RR_EN to check round-robin alternation.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, ic_gnt, ic_rvalid, ic_rlast, ic_kill;
  logic [31:0] ic_addr;
  logic [63:0] ic_rdata;
  logic        dc_req, dc_we, dc_gnt, dc_rvalid, dc_rlast, dc_bdone;
  logic [31:0] dc_addr;
  logic [63:0] dc_wdata, dc_rdata;
  logic [7:0]  dc_wstrb;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, wstrb;
  logic [63:0] rdata, wdata;
  logic        awvalid, awready, wvalid, wready, wlast;
  logic        bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_dc;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_BEATS(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .ic_rlast(ic_rlast), .ic_kill(ic_kill),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_gnt(dc_gnt),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_rlast(dc_rlast), .dc_bdone(dc_bdone),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic rbeat(input string tag, input logic [63:0] d,
                       input bit last, input bit e_ic, input bit e_dc);
    nxt();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = d;
    rlast   = last;
    smp();
    chk({tag, "_rready"}, rready, 1'b1);
    chk({tag, "_icrv"}, ic_rvalid, e_ic);
    chk({tag, "_dcrv"}, dc_rvalid, e_dc);
    chk({tag, "_iclast"}, ic_rlast, e_ic & last);
    chk({tag, "_dclast"}, dc_rlast, e_dc & last);
    if (e_ic) chk({tag, "_icdata"}, ic_rdata, d);
    if (e_dc) chk({tag, "_dcdata"}, dc_rdata, d);
  endtask

  task automatic rdone(input string tag);
    nxt();
    rvalid = 1'b0;
    rlast  = 1'b0;
    smp();
    chk({tag, "_idle"}, rready, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    ic_addr = '0; ic_kill = 1'b0;
    dc_we = 1'b0; dc_addr = '0; dc_wdata = '0; dc_wstrb = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // reset: grants held low even with requests pending
    smp();
    chk("rst_icgnt", ic_gnt, 1'b0);
    chk("rst_dcgnt", dc_gnt, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_bus", {awvalid, wvalid, rready, bready}, 4'b0);
    nxt();
    ic_req = 1'b0; dc_req = 1'b0;
    rst = 1'b1;
    smp();

    // icache 2-beat line refill
    nxt();
    ic_req = 1'b1; ic_addr = 32'h8000_0000;
    smp();
    chk("t1_icgnt", ic_gnt, 1'b1);
    chk("t1_dcgnt", dc_gnt, 1'b0);
    nxt();
    ic_req = 1'b0;
    smp();
    chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_araddr", araddr, 32'h8000_0000);
    chk("t1_arlen", arlen, 8'd1);
    chk("t1_gnt_once", ic_gnt, 1'b0);
    nxt();
    arready = 1'b1;
    smp();
    chk("t1_arhold", arvalid, 1'b1);
    rbeat("t1_b0", 64'h11, 1'b0, 1'b1, 1'b0);
    rbeat("t1_b1", 64'h22, 1'b1, 1'b1, 1'b0);
    rdone("t1");
    chk("t1_arvalid_end", arvalid, 1'b0);

    // simultaneous: dcache first, icache on next IDLE
    nxt();
    ic_req = 1'b1; ic_addr = 32'h8000_0040;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h8000_1000;
    smp();
    chk("t2_dcgnt", dc_gnt, 1'b1);
    chk("t2_icgnt", ic_gnt, 1'b0);
    nxt();
    dc_req = 1'b0; arready = 1'b1;
    smp();
    chk("t2_araddr", araddr, 32'h8000_1000);
    chk("t2_arlen", arlen, 8'd0);
    chk("t2_icwait", ic_gnt, 1'b0);
    rbeat("t2_dc", 64'h33, 1'b1, 1'b0, 1'b1);
    nxt();
    rvalid = 1'b0; rlast = 1'b0;
    smp();
    chk("t2_icgnt_after", ic_gnt, 1'b1);
    nxt();
    ic_req = 1'b0; arready = 1'b1;
    smp();
    chk("t2_ic_araddr", araddr, 32'h8000_0040);
    chk("t2_ic_arlen", arlen, 8'd1);
    rbeat("t2_ib0", 64'h44, 1'b0, 1'b1, 1'b0);
    rbeat("t2_ib1", 64'h55, 1'b1, 1'b1, 1'b0);
    rdone("t2");

    // three back-to-back simultaneous requests, early rlast
    for (int i = 0; i < 3; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_dc = (i != 1);
`else
      exp_dc = 1'b1;
`endif
      nxt();
      ic_req = 1'b1; ic_addr = 32'h8000_0100;
      dc_req = 1'b1; dc_addr = 32'h8000_4000;
      smp();
      chk($sformatf("t3_dcgnt%0d", i), dc_gnt, exp_dc);
      chk($sformatf("t3_icgnt%0d", i), ic_gnt, !exp_dc);
      nxt();
      ic_req = 1'b0; dc_req = 1'b0; arready = 1'b1;
      smp();
      chk($sformatf("t3_arlen%0d", i), arlen,
          exp_dc ? 8'd0 : 8'd1);
      rbeat($sformatf("t3_r%0d", i), 64'h100 + 64'(i),
            1'b1, !exp_dc, exp_dc);
      rdone($sformatf("t3_%0d", i));
    end

    // dcache write with slow awready
    nxt();
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h8000_2000;
    dc_wdata = 64'hDEAD_BEEF; dc_wstrb = 8'h0F;
    smp();
    chk("t4_dcgnt", dc_gnt, 1'b1);
    for (int k = 0; k < 3; k++) begin
      nxt();
      if (k == 0) begin
        dc_req = 1'b0; dc_we = 1'b0;
        dc_wdata = '0; dc_wstrb = '0; dc_addr = '0;
      end
      smp();
      chk($sformatf("t4_awvalid%0d", k), awvalid, 1'b1);
      chk($sformatf("t4_awaddr%0d", k), awaddr, 32'h8000_2000);
    end
    nxt();
    awready = 1'b1;
    smp();
    chk("t4_aw_hs", awvalid, 1'b1);
    nxt();
    awready = 1'b0;
    smp();
    chk("t4_awdone", awvalid, 1'b0);
    chk("t4_wvalid", wvalid, 1'b1);
    chk("t4_wlast", wlast, 1'b1);
    chk("t4_wdata", wdata, 64'hDEAD_BEEF);
    chk("t4_wstrb", wstrb, 8'h0F);
    nxt();
    wready = 1'b1;
    smp();
    chk("t4_w_hs", wvalid, 1'b1);
    nxt();
    wready = 1'b0;
    smp();
    chk("t4_bready", bready, 1'b1);
    chk("t4_wvalid_end", wvalid, 1'b0);
    chk("t4_bdone_pre", dc_bdone, 1'b0);
    nxt();
    bvalid = 1'b1;
    smp();
    chk("t4_bdone", dc_bdone, 1'b1);
    nxt();
    bvalid = 1'b0;
    smp();
    chk("t4_bdone_post", dc_bdone, 1'b0);
    chk("t4_bready_end", bready, 1'b0);

    // ic_kill after first beat
    nxt();
    ic_req = 1'b1; ic_addr = 32'h8000_0080;
    smp();
    chk("t5_icgnt", ic_gnt, 1'b1);
    nxt();
    ic_req = 1'b0; arready = 1'b1;
    smp();
    rbeat("t5_b0", 64'h66, 1'b0, 1'b1, 1'b0);
    nxt();
    rvalid = 1'b0; ic_kill = 1'b1;
    smp();
    chk("t5_kill_rready", rready, 1'b1);
    rbeat("t5_b1", 64'h77, 1'b1, 1'b0, 1'b0);
    ic_kill = 1'b0;
    rdone("t5");
    // kill while idle is ignored
    nxt();
    ic_req = 1'b1; ic_kill = 1'b1; ic_addr = 32'h8000_00C0;
    smp();
    chk("t5_regnt", ic_gnt, 1'b1);
    nxt();
    ic_req = 1'b0; ic_kill = 1'b0; arready = 1'b1;
    smp();
    chk("t5_readdr", araddr, 32'h8000_00C0);
    rbeat("t5_n0", 64'h88, 1'b0, 1'b1, 1'b0);
    rbeat("t5_n1", 64'h99, 1'b1, 1'b1, 1'b0);
    rdone("t5n");

    // reset during RDATA
    nxt();
    ic_req = 1'b1; ic_addr = 32'h8000_0200;
    smp();
    nxt();
    ic_req = 1'b0; arready = 1'b1;
    smp();
    rbeat("t6_b0", 64'hAA, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_icrv", ic_rvalid, 1'b0);
    chk("t6_rready", rready, 1'b0);
    chk("t6_arvalid", arvalid, 1'b0);
    nxt();
    rvalid = 1'b0; rlast = 1'b0;
    smp();
    chk("t6_hold", {rready, arvalid, awvalid, wvalid}, 4'b0);
    nxt();
    rst = 1'b1;
    smp();
    nxt();
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h8000_3000;
    smp();
    chk("t6_dcgnt", dc_gnt, 1'b1);
    nxt();
    dc_req = 1'b0; arready = 1'b1;
    smp();
    chk("t6_araddr", araddr, 32'h8000_3000);
    chk("t6_arlen", arlen, 8'd0);
    rbeat("t6_dc", 64'hBB, 1'b1, 1'b0, 1'b1);
    rdone("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
